// File: rtl/mbist_repair_pkg.sv
// Shared types and sizing for the MBIST repair-address scan controller.
package mbist_repair_pkg;

    localparam int BIST_ERR_LIMIT     = 4;
    localparam int REPAIR_NUM_ENTRIES = BIST_ERR_LIMIT;
    localparam int REPAIR_ENTRY_WD    = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        SHIFT,
        DONE
    } repair_scan_st_e;

endpackage

// File: rtl/mbist_repair_scan_buf.sv
// NUM_ENTRIES x ENTRY_WD register file: word write, bit-addressed serial write, word read.
// Out-of-range indices drop writes and read as zero.
module mbist_repair_scan_buf
    import mbist_repair_pkg::*;
#(
    parameter int NUM_ENTRIES = REPAIR_NUM_ENTRIES,
    parameter int ENTRY_WD    = REPAIR_ENTRY_WD,
    parameter int IDX_WD      = $clog2(NUM_ENTRIES),
    parameter int POS_WD      = $clog2(NUM_ENTRIES * ENTRY_WD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                word_we,
    input  logic [IDX_WD-1:0]   word_idx,
    input  logic [ENTRY_WD-1:0] word_data,
    input  logic                bit_we,
    input  logic [POS_WD-1:0]   bit_pos,
    input  logic                bit_val,
    input  logic [IDX_WD-1:0]   rd_idx,
    output logic [ENTRY_WD-1:0] rd_data
);

    logic [ENTRY_WD-1:0] mem [NUM_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) mem[e] <= '0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (word_we && int'(word_idx) == e) mem[e] <= word_data;
                for (int b = 0; b < ENTRY_WD; b++) begin
                    if (bit_we && int'(bit_pos) == e * ENTRY_WD + b) mem[e][b] <= bit_val;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (int'(rd_idx) == e) rd_data = mem[e];
        end
    end

endmodule

// File: rtl/mbist_repair_scan_ctrl.sv
// Serial scan sequencer for one MBIST repair-address chain: UNLOAD into a capture buffer, optional LOAD from a host buffer.
// Define MBIST_REPAIR_SCAN_PARITY_EN to add a round-trip parity check reported on parity_err.
module mbist_repair_scan_ctrl
    import mbist_repair_pkg::*;
#(
    parameter int NUM_ENTRIES = REPAIR_NUM_ENTRIES,
    parameter int ENTRY_WD    = REPAIR_ENTRY_WD,
    parameter int IDX_WD      = $clog2(NUM_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_load,
    input  logic                wr_en,
    input  logic [IDX_WD-1:0]   wr_idx,
    input  logic [ENTRY_WD-1:0] wr_data,
    input  logic [IDX_WD-1:0]   rd_idx,
    output logic [ENTRY_WD-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                scan_shift,
    output logic                sdi,
    input  logic                sdo,
    output logic                parity_err
);

    localparam int NUM_BITS = NUM_ENTRIES * ENTRY_WD;
    localparam int CNT_WD   = $clog2(NUM_BITS);
    localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(NUM_BITS - 1);

    repair_scan_st_e     state, state_nxt;
    logic [CNT_WD-1:0]   bit_cnt;
    logic [CNT_WD-1:0]   sdi_pos;
    logic [IDX_WD-1:0]   sdi_idx;
    logic [ENTRY_WD-1:0] sdi_word;
    logic                sdi_bit;
    logic                load_q;
    logic                shift_q;
    logic                sdi_q;
    logic                accept;
    logic                cap_we;
    logic                load_we;

    assign accept  = (state == IDLE) && cmd_valid;
    assign load_we = (state == IDLE) && wr_en;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cap_we    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = PRELOAD;
            end
            PRELOAD: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy   = 1'b1;
                cap_we = 1'b1;
                if (bit_cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sdi is registered, so look up the bit that will be on the wire next cycle
    assign sdi_pos = (state == SHIFT) ? bit_cnt + CNT_WD'(1) : '0;
    assign sdi_idx = IDX_WD'(int'(sdi_pos) / ENTRY_WD);

    always_comb begin
        sdi_bit = 1'b0;
        for (int b = 0; b < ENTRY_WD; b++) begin
            if (int'(sdi_pos) % ENTRY_WD == b) sdi_bit = sdi_word[b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) load_q <= cmd_load;
            if (state == PRELOAD)    bit_cnt <= '0;
            else if (state == SHIFT) bit_cnt <= bit_cnt + CNT_WD'(1);
            shift_q <= (state_nxt == SHIFT);
            sdi_q   <= (state_nxt == SHIFT) && load_q && sdi_bit;
        end
    end

    assign scan_shift = shift_q;
    assign sdi        = sdi_q;

    mbist_repair_scan_buf #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ENTRY_WD    (ENTRY_WD),
        .IDX_WD      (IDX_WD),
        .POS_WD      (CNT_WD)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .word_we   (1'b0),
        .word_idx  ('0),
        .word_data ('0),
        .bit_we    (cap_we),
        .bit_pos   (bit_cnt),
        .bit_val   (sdo),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    mbist_repair_scan_buf #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ENTRY_WD    (ENTRY_WD),
        .IDX_WD      (IDX_WD),
        .POS_WD      (CNT_WD)
    ) u_load (
        .clk       (clk),
        .rst       (rst),
        .word_we   (load_we),
        .word_idx  (wr_idx),
        .word_data (wr_data),
        .bit_we    (1'b0),
        .bit_pos   ('0),
        .bit_val   (1'b0),
        .rd_idx    (sdi_idx),
        .rd_data   (sdi_word)
    );

`ifdef MBIST_REPAIR_SCAN_PARITY_EN
    logic par_cap;
    logic par_load;
    logic par_ref;
    logic par_err_q;

    // par_ref holds the parity of the bits pushed in by the most recent completed LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_cap   <= 1'b0;
            par_load  <= 1'b0;
            par_ref   <= 1'b0;
            par_err_q <= 1'b0;
        end else if (accept) begin
            par_cap   <= 1'b0;
            par_load  <= 1'b0;
            par_err_q <= 1'b0;
        end else if (state == SHIFT) begin
            par_cap  <= par_cap ^ sdo;
            par_load <= par_load ^ sdi_q;
        end else if (state == DONE) begin
            if (par_cap != par_ref) par_err_q <= 1'b1;
            if (load_q) par_ref <= par_load;
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_repair_scan_ctrl.sv
// Directed self-checking bench for mbist_repair_scan_ctrl against a 64-bit shift-register model of the repair chain.
module tb_mbist_repair_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_load;
    logic        wr_en;
    logic [2:0]  wr_idx, rd_idx;
    logic [15:0] wr_data, rd_data;
    logic        busy, done, scan_shift, sdi, sdo, parity_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] chain;
    logic [63:0] chain_init;
    logic        chain_set;
    int          shift_n;
    logic        flip_en;
    int          flip_at;

    int          n_shift, first_shift, done_at, ready_bad;
    logic [63:0] sdi_seq;

    always #5 clk = ~clk;

    mbist_repair_scan_ctrl #(.IDX_WD(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .scan_shift (scan_shift),
        .sdi        (sdi),
        .sdo        (sdo),
        .parity_err (parity_err)
    );

    // repair chain model: entry 0 bit 0 sits at chain[0] and leaves first
    assign sdo = chain[0] ^ (flip_en && shift_n == flip_at);

    always @(posedge clk) begin
        if (chain_set) begin
            chain   <= chain_init;
            shift_n <= 0;
        end else if (scan_shift) begin
            chain   <= {sdi, chain[63:1]};
            shift_n <= shift_n + 1;
        end else begin
            shift_n <= 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input logic [2:0] idx, input logic [15:0] exp);
        rd_idx = idx;
        #1;
        check($sformatf("rd_data[%0d]", idx), {48'd0, rd_data}, {48'd0, exp});
    endtask

    task automatic load_chain(input logic [63:0] val);
        chain_init = val;
        chain_set  = 1'b1;
        @(negedge clk);
        chain_set  = 1'b0;
    endtask

    task automatic host_write(input logic [2:0] idx, input logic [15:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issue one command from IDLE and watch it; t counts cycles after the accept edge.
    task automatic run_seq(input logic load, input logic we, input logic [2:0] widx,
                           input logic [15:0] wdata, input logic busy_wr);
        n_shift = 0; first_shift = -1; done_at = -1; ready_bad = 0; sdi_seq = '0;
        cmd_valid = 1'b1; cmd_load = load;
        wr_en = we; wr_idx = widx; wr_data = wdata;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (t == 1) begin cmd_valid = 1'b0; wr_en = 1'b0; end
            if (busy_wr && t == 10) begin wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'hDEAD; end
            if (busy_wr && t == 11) wr_en = 1'b0;
            if (scan_shift === 1'b1) begin
                if (first_shift < 0) first_shift = t;
                if (n_shift < 64) sdi_seq[n_shift[5:0]] = sdi;
                n_shift++;
            end
            if (t <= 65 && (cmd_ready !== 1'b0 || busy !== 1'b1)) ready_bad++;
            if (done === 1'b1) begin
                done_at = t;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, bad;
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        chain_init = '0; chain_set = 1'b1; flip_en = 1'b0; flip_at = 0;
        repeat (3) @(negedge clk);
        chain_set = 1'b0;

        check("rst cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst scan_shift", {63'd0, scan_shift}, 64'd0);
        check("rst sdi", {63'd0, sdi}, 64'd0);
        check("rst parity_err", {63'd0, parity_err}, 64'd0);
        check_rd(3'd0, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // UNLOAD of a known chain
        load_chain(64'h1234_0000_0003_01FC);
        run_seq(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("unload shift count", n_shift, 64);
        check("unload first shift", first_shift, 2);
        check("unload done cycle", done_at, 66);
        check("unload ready/busy", ready_bad, 0);
        check("unload sdi zero", sdi_seq, 64'd0);
        check_rd(3'd0, 16'h01FC);
        check_rd(3'd1, 16'h0003);
        check_rd(3'd2, 16'h0000);
        check_rd(3'd3, 16'h1234);

        // cmd_valid held for 200 cycles: three back-to-back sequences, no queuing
        n_done = 0; bad = 0;
        cmd_valid = 1'b1; cmd_load = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1 && cmd_ready !== 1'b0) bad++;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("held done count", n_done, 3);
        check("held ready while busy", bad, 0);
        check("held idle busy", {63'd0, busy}, 64'd0);

        // LOAD: fill buffer, out-of-range write, same-cycle write with the command, write while busy
        host_write(3'd0, 16'hAAAA);
        host_write(3'd1, 16'h5555);
        host_write(3'd2, 16'h0000);
        host_write(3'd3, 16'hFF00);
        host_write(3'd7, 16'hBEEF);
        load_chain(64'h0123_4567_89AB_CDEF);
        run_seq(1'b1, 1'b1, 3'd2, 16'h00FF, 1'b1);
        check("load sdi sequence", sdi_seq, 64'hFF00_00FF_5555_AAAA);
        check("load shift count", n_shift, 64);
        check("load done cycle", done_at, 66);
        check_rd(3'd0, 16'hCDEF);
        check_rd(3'd3, 16'h0123);

        run_seq(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check_rd(3'd0, 16'hAAAA);
        check_rd(3'd1, 16'h5555);
        check_rd(3'd2, 16'h00FF);
        check_rd(3'd3, 16'hFF00);
        check_rd(3'd7, 16'h0000);

        // reset in the middle of SHIFT at bit 20
        load_chain(64'h1234_0000_0003_01FC);
        cmd_valid = 1'b1; cmd_load = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (21) @(negedge clk);
        check("pre-rst scan_shift", {63'd0, scan_shift}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst mid scan_shift", {63'd0, scan_shift}, 64'd0);
        check("rst mid busy", {63'd0, busy}, 64'd0);
        check("rst mid cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check_rd(3'd0, 16'h0000);
        check_rd(3'd1, 16'h0000);
        check_rd(3'd2, 16'h0000);
        check_rd(3'd3, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef MBIST_REPAIR_SCAN_PARITY_EN
        host_write(3'd0, 16'hAAAA);
        host_write(3'd1, 16'h5555);
        host_write(3'd2, 16'h00FF);
        host_write(3'd3, 16'hFF00);
        load_chain(64'd0);
        run_seq(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        flip_en = 1'b1; flip_at = 5;
        run_seq(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        flip_en = 1'b0;
        check("parity after flip", {63'd0, parity_err}, 64'd1);
        check_rd(3'd0, 16'hAA8A);
        run_seq(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        check("parity clean load", {63'd0, parity_err}, 64'd0);
        run_seq(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("parity clean unload", {63'd0, parity_err}, 64'd0);
        check_rd(3'd0, 16'hAAAA);
`else
        run_seq(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("post-rst done cycle", done_at, 66);
        check("parity tied low", {63'd0, parity_err}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
